// File: rtl/debug_commit_tracker.sv
// -----------------------------------------------------------------------------
// debug_commit_tracker
//
// Builds the per-instruction commit trace for the simulation debug sink.
// Each retire from writeback (wb_valid) produces one registered commit record
// on debug_* one cycle later. Device (MMIO) accesses seen on the LSU strobe are
// bound to the instruction that retires with them, or to the next retire after
// them. An ebreak retire emits a halting record and freezes the core until
// reset.
//
// Optional feature (macro DEBUG_WATCHDOG_EN): a watchdog counts RUN cycles
// without a retire. After WDT_CYCLES idle cycles it emits a halting record
// with wdt_timeout=1.
//
// Ports:
//   clock, reset          - clock; synchronous active-high reset
//   wb_valid/pc/inst      - retire strobe, PC and encoding of the retiring inst
//   wb_regWen/Waddr/Wdata - GPR write of the retiring instruction
//   lsu_valid/lsu_addr    - LSU access strobe and address
//   debug_*               - registered commit record (debug_valid = 1-cycle pulse)
//   halted                - freeze request, held until reset
//   instret               - 64-bit retired-instruction count (wraps)
//   wdt_timeout           - halt was caused by the watchdog
// -----------------------------------------------------------------------------
module debug_commit_tracker #(
    parameter logic [31:0] DEV_BASE   = 32'ha000_0000,
    parameter logic [31:0] DEV_MASK   = 32'hf000_0000,
    parameter int unsigned WDT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_inst,
    input  logic        wb_regWen,
    input  logic [4:0]  wb_regWaddr,
    input  logic [31:0] wb_regWdata,
    input  logic        lsu_valid,
    input  logic [31:0] lsu_addr,
    output logic        debug_valid,
    output logic        debug_halt,
    output logic        debug_deviceAccess,
    output logic [31:0] debug_deviceAddr,
    output logic [31:0] debug_pc,
    output logic        debug_regWen,
    output logic [4:0]  debug_regWaddr,
    output logic [31:0] debug_regWdata,
    output logic        halted,
    output logic [63:0] instret,
    output logic        wdt_timeout
);

    localparam logic [0:0]  ST_RUN    = 1'b0;
    localparam logic [0:0]  ST_HALTED = 1'b1;
    localparam logic [31:0] EBREAK    = 32'h0010_0073;

    // FSM and pending-device state
    logic [0:0]  r_state;
    logic        r_dev_pend;
    logic [31:0] r_dev_addr;

    // Registered commit record
    logic        r_valid;
    logic        r_halt;
    logic        r_dev_acc;
    logic [31:0] r_dev_out;
    logic [31:0] r_pc;
    logic        r_regWen;
    logic [4:0]  r_regWaddr;
    logic [31:0] r_regWdata;
    logic        r_halted;
    logic [63:0] r_instret;

    logic        w_run;
    logic        w_retire;
    logic        w_ebreak;
    logic        w_lsu_dev;
    logic        w_rec_dev;
    logic [31:0] w_rec_addr;
    logic        w_wdt_fire;

    assign w_run     = (r_state == ST_RUN);
    assign w_retire  = w_run && wb_valid;
    assign w_ebreak  = w_retire && (wb_inst == EBREAK);
    // LSU is ignored once halted, so a device hit only counts in RUN
    assign w_lsu_dev = w_run && lsu_valid && ((lsu_addr & DEV_MASK) == DEV_BASE);

    // An already pending access is older than a same-cycle one, so it wins.
    assign w_rec_dev  = r_dev_pend || w_lsu_dev;
    assign w_rec_addr = r_dev_pend ? r_dev_addr :
                        (w_lsu_dev ? lsu_addr : 32'h0);

`ifdef DEBUG_WATCHDOG_EN
    logic [31:0] r_wdt_cnt;
    logic [31:0] r_last_pc;
    logic        r_wdt_timeout;

    // A retire in the limit cycle wins over the timeout
    assign w_wdt_fire = w_run && !wb_valid && (r_wdt_cnt == 32'(WDT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wdt_cnt     <= 32'h0;
            r_last_pc     <= 32'h0;
            r_wdt_timeout <= 1'b0;
        end else begin
            if (w_retire) begin
                r_wdt_cnt <= 32'h0;
                r_last_pc <= wb_pc;
            end else if (w_run) begin
                r_wdt_cnt <= r_wdt_cnt + 32'h1;
            end
            if (w_wdt_fire)
                r_wdt_timeout <= 1'b1;
        end
    end

    assign wdt_timeout = r_wdt_timeout;
`else
    assign w_wdt_fire  = 1'b0;
    assign wdt_timeout = 1'b0;
    // Parameter only meaningful with the watchdog built in
    logic w_unused_wdt;
    assign w_unused_wdt = ^WDT_CYCLES;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_dev_pend <= 1'b0;
            r_dev_addr <= 32'h0;
            r_valid    <= 1'b0;
            r_halt     <= 1'b0;
            r_dev_acc  <= 1'b0;
            r_dev_out  <= 32'h0;
            r_pc       <= 32'h0;
            r_regWen   <= 1'b0;
            r_regWaddr <= 5'h0;
            r_regWdata <= 32'h0;
            r_halted   <= 1'b0;
            r_instret  <= 64'h0;
        end else begin
            // Pulse by default; the record fields hold otherwise
            r_valid <= 1'b0;
            if (w_retire) begin
                r_valid    <= 1'b1;
                r_halt     <= w_ebreak;
                r_dev_acc  <= w_rec_dev;
                r_dev_out  <= w_rec_addr;
                r_pc       <= wb_pc;
                r_regWen   <= wb_regWen && (wb_regWaddr != 5'd0);
                r_regWaddr <= wb_regWaddr;
                r_regWdata <= wb_regWdata;
                r_instret  <= r_instret + 64'h1;
                // Access (pending or same-cycle) is consumed by this record
                r_dev_pend <= 1'b0;
                r_dev_addr <= 32'h0;
                if (w_ebreak) begin
                    r_state  <= ST_HALTED;
                    r_halted <= 1'b1;
                end
            end else begin
                // First device address wins until the next retire
                if (w_lsu_dev && !r_dev_pend) begin
                    r_dev_pend <= 1'b1;
                    r_dev_addr <= lsu_addr;
                end
`ifdef DEBUG_WATCHDOG_EN
                if (w_wdt_fire) begin
                    r_valid    <= 1'b1;
                    r_halt     <= 1'b1;
                    r_dev_acc  <= 1'b0;
                    r_dev_out  <= 32'h0;
                    r_pc       <= r_last_pc;
                    r_regWen   <= 1'b0;
                    r_regWaddr <= 5'h0;
                    r_regWdata <= 32'h0;
                    r_state    <= ST_HALTED;
                    r_halted   <= 1'b1;
                end
`else
                if (w_wdt_fire) begin
                    r_state <= ST_HALTED;
                end
`endif
            end
        end
    end

    assign debug_valid        = r_valid;
    assign debug_halt         = r_halt;
    assign debug_deviceAccess = r_dev_acc;
    assign debug_deviceAddr   = r_dev_out;
    assign debug_pc           = r_pc;
    assign debug_regWen       = r_regWen;
    assign debug_regWaddr     = r_regWaddr;
    assign debug_regWdata     = r_regWdata;
    assign halted             = r_halted;
    assign instret            = r_instret;

endmodule
